// File: rtl/execute_stage_if.sv
// Bundle between decode/writeback and the uRISC execute stage.
// master = driving side (decode/writeback), slave = execute stage.
interface execute_stage_if #(
    parameter int DW = 16
);
    logic [2:0]    rs_in;
    logic [2:0]    rt_in;
    logic [2:0]    rd_in;
    logic          wr;
    logic          en;
    logic [DW-1:0] data_in;
    logic          excep;
    logic [DW-1:0] pc;
    logic [25:0]   uop_cnt_idix_p1;
    logic          execute_valid_idix_p1;
    logic          ldst_valid_idix_p1;
    logic          jmp_idix_p1;
    logic          branch_idix_p1;
    logic [4:0]    opcode_idix_p1;
    logic          rotate_shift_right_idix_p1;
    logic [DW-1:0] pc_p1;
    logic [2:0]    rs_idix_p1;
    logic [2:0]    rt_idix_p1;
    logic [2:0]    rd_idix_p1;
    logic [DW-1:0] rs_p1;
    logic [DW-1:0] rt_p1;
    logic [DW-1:0] rd_p1;
    logic          wr_success_p1;
    logic [DW-1:0] epc_p1;
    logic          alu_output_valid;

    modport master (
        output rs_in, rt_in, rd_in, wr, en, data_in, excep, pc,
               uop_cnt_idix_p1, execute_valid_idix_p1, ldst_valid_idix_p1,
               jmp_idix_p1, branch_idix_p1, opcode_idix_p1,
               rotate_shift_right_idix_p1, pc_p1, rs_idix_p1, rt_idix_p1, rd_idix_p1,
        input  rs_p1, rt_p1, rd_p1, wr_success_p1, epc_p1, alu_output_valid
    );

    modport slave (
        input  rs_in, rt_in, rd_in, wr, en, data_in, excep, pc,
               uop_cnt_idix_p1, execute_valid_idix_p1, ldst_valid_idix_p1,
               jmp_idix_p1, branch_idix_p1, opcode_idix_p1,
               rotate_shift_right_idix_p1, pc_p1, rs_idix_p1, rt_idix_p1, rd_idix_p1,
        output rs_p1, rt_p1, rd_p1, wr_success_p1, epc_p1, alu_output_valid
    );
endinterface

// File: rtl/execute_stage.sv
// uRISC execute stage: register file, operand latches, EPC capture, combinational ALU/shifter.
// Optional macro EXEC_FORWARD_EN: write-through bypass of same-edge writeback into the operand latches.
module execute_stage #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input logic            clk,
    input logic            rst,
    execute_stage_if.slave io
);
    localparam int AW = $clog2(DW);

    logic [NREG-1:0][DW-1:0] regs;
    logic [DW-1:0]           a, b;
    logic [AW-1:0]           amt;
    logic [2*DW-1:0]         dbl, dbl_shl, dbl_shr;
    logic [DW-1:0]           shift_res, brev, alu_res, res;
    logic [DW:0]             sum_c;
    logic                    unused_ok;

    assign a = io.rs_p1;
    assign b = io.rt_p1;

    // Decode-stage tags and reserved micro-op bits are accepted but ignored.
    assign unused_ok = ^{io.rs_idix_p1, io.rt_idix_p1, io.rd_idix_p1,
                         io.uop_cnt_idix_p1[25:5], io.uop_cnt_idix_p1[3:0], io.rt_p1[DW-1:AW]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs             <= '0;
            io.rs_p1         <= '0;
            io.rt_p1         <= '0;
            io.epc_p1        <= '0;
            io.wr_success_p1 <= 1'b0;
        end else begin
            io.wr_success_p1 <= io.en & io.wr;
            if (io.en & io.wr)
                regs[io.rd_in] <= io.data_in;
            if (io.en & io.excep)
                io.epc_p1 <= io.pc;
            if (io.en) begin
`ifdef EXEC_FORWARD_EN
                io.rs_p1 <= (io.wr && io.rd_in == io.rs_in) ? io.data_in : regs[io.rs_in];
                io.rt_p1 <= (io.wr && io.rd_in == io.rt_in) ? io.data_in : regs[io.rt_in];
`else
                // Non-blocking read sees the pre-write contents on a same-edge write.
                io.rs_p1 <= regs[io.rs_in];
                io.rt_p1 <= regs[io.rt_in];
`endif
            end
        end
    end

    // Rotates come from a doubled operand so amt=0 needs no special case.
    assign amt     = io.rt_p1[AW-1:0];
    assign dbl     = {a, a};
    assign dbl_shl = dbl << amt;
    assign dbl_shr = dbl >> amt;

    always_comb begin
        shift_res = '0;
        case ({io.uop_cnt_idix_p1[4], io.rotate_shift_right_idix_p1})
            2'b00:   shift_res = a << amt;
            2'b01:   shift_res = a >> amt;
            2'b10:   shift_res = dbl_shl[2*DW-1:DW];
            default: shift_res = dbl_shr[DW-1:0];
        endcase
    end

    always_comb begin
        brev = '0;
        for (int i = 0; i < DW; i++)
            brev[i] = a[DW-1-i];
    end

    assign sum_c = {1'b0, a} + {1'b0, b};

    always_comb begin
        alu_res = '0;
        case (io.opcode_idix_p1)
            5'd0:    alu_res = sum_c[DW-1:0];
            5'd1:    alu_res = b - a;
            5'd2:    alu_res = a ^ b;
            5'd3:    alu_res = a & ~b;
            5'd4:    alu_res = shift_res;
            5'd5:    alu_res = {{(DW-1){1'b0}}, a == b};
            5'd6:    alu_res = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            5'd7:    alu_res = {{(DW-1){1'b0}}, $signed(a) <= $signed(b)};
            5'd8:    alu_res = {{(DW-1){1'b0}}, sum_c[DW]};
            5'd9:    alu_res = brev;
            5'd10:   alu_res = b;
            5'd11:   alu_res = (a << 8) | {{(DW-8){1'b0}}, b[7:0]};
            5'd12:   alu_res = io.pc_p1 + DW'(2);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        res = alu_res;
        if (io.jmp_idix_p1)
            res = io.pc_p1 + DW'(2);
        else if (io.ldst_valid_idix_p1)
            res = sum_c[DW-1:0];
        else if (io.branch_idix_p1)
            res = {{(DW-1){1'b0}}, a == '0};
    end

    assign io.rd_p1            = res;
    assign io.alu_output_valid = io.execute_valid_idix_p1 & io.en;
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    execute_stage_if #(.DW(16)) io ();
    execute_stage #(.DW(16), .NREG(8)) dut (.clk(clk), .rst(rst), .io(io));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [15:0] val);
        io.en = 1'b1; io.wr = 1'b1; io.rd_in = idx; io.data_in = val;
        tick();
        io.wr = 1'b0;
    endtask

    task automatic latch(input logic [2:0] rs, input logic [2:0] rt);
        io.en = 1'b1; io.rs_in = rs; io.rt_in = rt;
        tick();
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] fwd_exp;
        io.rs_in = 0; io.rt_in = 0; io.rd_in = 0; io.wr = 0; io.en = 0;
        io.data_in = 0; io.excep = 0; io.pc = 0; io.uop_cnt_idix_p1 = 0;
        io.execute_valid_idix_p1 = 0; io.ldst_valid_idix_p1 = 0; io.jmp_idix_p1 = 0;
        io.branch_idix_p1 = 0; io.opcode_idix_p1 = 0; io.rotate_shift_right_idix_p1 = 0;
        io.pc_p1 = 0; io.rs_idix_p1 = 0; io.rt_idix_p1 = 0; io.rd_idix_p1 = 0;

        // Reset state
        tick();
        check("rst_rs_p1", io.rs_p1, 16'h0);
        check("rst_rt_p1", io.rt_p1, 16'h0);
        check("rst_epc", io.epc_p1, 16'h0);
        check("rst_wr_success", {15'b0, io.wr_success_p1}, 16'h0);
        check("rst_alu_valid", {15'b0, io.alu_output_valid}, 16'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            latch(3'(i), 3'(7 - i));
            check($sformatf("rst_reg%0d", i), io.rs_p1, 16'h0);
        end

        // Write R3 then read it back
        io.rs_in = 0;
        wr_reg(3, 16'h1234);
        check("wr_success_pulse", {15'b0, io.wr_success_p1}, 16'h1);
        io.rs_in = 3;
        tick();
        check("r3_readback", io.rs_p1, 16'h1234);
        check("wr_success_drop", {15'b0, io.wr_success_p1}, 16'h0);

        // Shift sweep
        io.opcode_idix_p1 = 5'd4;
        wr_reg(1, 16'h8FFF);
        for (int amt = 0; amt < 16; amt++) begin
            wr_reg(2, 16'(amt));
            latch(1, 2);
            v = 16'h8FFF;
            io.rotate_shift_right_idix_p1 = 1'b1; #1;
            check($sformatf("shr_%0d", amt), io.rd_p1, v >> amt);
            io.rotate_shift_right_idix_p1 = 1'b0; #1;
            check($sformatf("shl_%0d", amt), io.rd_p1, v << amt);
        end
        check("shr_spot_1", 16'h8FFF >> 1, 16'h47FF);

        // Rotate
        wr_reg(1, 16'h8001); wr_reg(2, 16'h0001); latch(1, 2);
        io.uop_cnt_idix_p1 = 26'h10;
        io.rotate_shift_right_idix_p1 = 1'b0; #1;
        check("rotl_1", io.rd_p1, 16'h0003);
        io.rotate_shift_right_idix_p1 = 1'b1; #1;
        check("rotr_1", io.rd_p1, 16'hC000);
        io.uop_cnt_idix_p1 = 26'h0;
        io.rotate_shift_right_idix_p1 = 1'b0;

        // ALU ops with A=0xFFFF, B=0x0001
        wr_reg(1, 16'hFFFF); latch(1, 2);
        io.opcode_idix_p1 = 5'd8;  #1; check("carry", io.rd_p1, 16'h0001);
        io.opcode_idix_p1 = 5'd6;  #1; check("slt", io.rd_p1, 16'h0001);
        io.opcode_idix_p1 = 5'd7;  #1; check("sle", io.rd_p1, 16'h0001);
        io.opcode_idix_p1 = 5'd0;  #1; check("add", io.rd_p1, 16'h0000);
        io.opcode_idix_p1 = 5'd1;  #1; check("sub_b_a", io.rd_p1, 16'h0002);
        io.opcode_idix_p1 = 5'd2;  #1; check("xor", io.rd_p1, 16'hFFFE);
        io.opcode_idix_p1 = 5'd3;  #1; check("andn", io.rd_p1, 16'hFFFE);
        io.opcode_idix_p1 = 5'd5;  #1; check("eq", io.rd_p1, 16'h0000);
        io.opcode_idix_p1 = 5'd10; #1; check("passb", io.rd_p1, 16'h0001);
        io.opcode_idix_p1 = 5'd11; #1; check("lui", io.rd_p1, 16'hFF01);
        io.opcode_idix_p1 = 5'd13; #1; check("op13_zero", io.rd_p1, 16'h0000);
        io.pc_p1 = 16'h0100;
        io.opcode_idix_p1 = 5'd12; #1; check("pc_plus2", io.rd_p1, 16'h0102);
        io.opcode_idix_p1 = 5'd8; io.jmp_idix_p1 = 1'b1; io.ldst_valid_idix_p1 = 1'b1; #1;
        check("jmp_prio", io.rd_p1, 16'h0102);
        io.jmp_idix_p1 = 1'b0; io.branch_idix_p1 = 1'b1; #1;
        check("ldst_prio", io.rd_p1, 16'h0000);
        io.ldst_valid_idix_p1 = 1'b0; #1;
        check("branch_nz", io.rd_p1, 16'h0000);
        latch(0, 2); #1;
        check("branch_z", io.rd_p1, 16'h0001);
        io.branch_idix_p1 = 1'b0;
        wr_reg(1, 16'h0001); latch(1, 1);
        io.opcode_idix_p1 = 5'd9; #1; check("bitrev", io.rd_p1, 16'h8000);
        io.opcode_idix_p1 = 5'd5; #1; check("eq_true", io.rd_p1, 16'h0001);

        // Output valid
        io.execute_valid_idix_p1 = 1'b1; io.en = 1'b1; #1;
        check("valid_on", {15'b0, io.alu_output_valid}, 16'h1);
        io.en = 1'b0; #1;
        check("valid_en0", {15'b0, io.alu_output_valid}, 16'h0);
        io.execute_valid_idix_p1 = 1'b0;

        // Exception capture and hold
        io.en = 1'b1; io.excep = 1'b1; io.pc = 16'h00AA; tick();
        check("epc_capture", io.epc_p1, 16'h00AA);
        io.en = 1'b0; io.pc = 16'h0055; tick();
        check("epc_hold_en0", io.epc_p1, 16'h00AA);
        io.en = 1'b1; io.excep = 1'b0; io.pc = 16'h0077; tick();
        check("epc_hold_noexc", io.epc_p1, 16'h00AA);

        // Simultaneous write and exception
        io.excep = 1'b1; io.pc = 16'h0123;
        wr_reg(6, 16'hBEEF);
        io.excep = 1'b0;
        check("wr_exc_epc", io.epc_p1, 16'h0123);
        check("wr_exc_ws", {15'b0, io.wr_success_p1}, 16'h1);
        latch(6, 6);
        check("wr_exc_reg", io.rt_p1, 16'hBEEF);

        // Operand hold with en=0
        io.en = 1'b0; io.rs_in = 0; tick();
        check("hold_en0", io.rs_p1, 16'hBEEF);
        io.en = 1'b1; io.wr = 1'b1; io.rd_in = 4; io.data_in = 16'h5A5A; io.en = 1'b0;
        tick(); io.wr = 1'b0;
        latch(4, 4);
        check("no_write_en0", io.rs_p1, 16'h0000);

        // Same-edge write/read of R5
        wr_reg(5, 16'h1111);
        io.rs_in = 5; io.rt_in = 5;
        wr_reg(5, 16'h2222);
`ifdef EXEC_FORWARD_EN
        fwd_exp = 16'h2222;
`else
        fwd_exp = 16'h1111;
`endif
        check("rdw_rs", io.rs_p1, fwd_exp);
        check("rdw_rt", io.rt_p1, fwd_exp);
        tick();
        check("rdw_after", io.rs_p1, 16'h2222);

        // Asynchronous reset mid-operation
        #2 rst = 1'b1; #1;
        check("async_rst_rs", io.rs_p1, 16'h0);
        check("async_rst_epc", io.epc_p1, 16'h0);
        tick(); rst = 1'b0;
        latch(6, 5);
        check("async_rst_r6", io.rs_p1, 16'h0);
        check("async_rst_r5", io.rt_p1, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 16-bit uRISC pipeline.
- Holds the 8x16 architectural register file and latches the two source operands into p1 flops.
- A combinational ALU/shifter drives the stage result from decode-stage (idix) controls.
- Also captures the exception PC. Sits between decode (idix_p1 signals) and writeback (rd_in/data_in/wr).

Parameters:
- DW, 16, datapath width; the design is only required to be correct at 16.
- NREG, 8, number of architectural registers (3-bit indices).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs_in  in  3  first source register read index.
- rt_in  in  3  second source register read index.
- rd_in  in  3  writeback destination register index.
- wr  in  1  writeback request.
- en  in  1  stage enable; gates every state update.
- data_in  in  16  writeback data.
- excep  in  1  exception flag.
- pc  in  16  PC of the excepting instruction.
- uop_cnt_idix_p1  in  26  one-hot micro-op vector; bit 4 = rotate select; other bits reserved.
- execute_valid_idix_p1  in  1  instruction valid in execute.
- ldst_valid_idix_p1  in  1  load/store: result is the address.
- jmp_idix_p1  in  1  jump-and-link: result is the link address.
- branch_idix_p1  in  1  branch: result is the condition.
- opcode_idix_p1  in  5  ALU opcode.
- rotate_shift_right_idix_p1  in  1  1 = right, 0 = left.
- pc_p1  in  16  PC of the executing instruction.
- rs_idix_p1, rt_idix_p1, rd_idix_p1  in  3 each  decode-stage index tags; accepted, no effect on outputs.
- rs_p1  out  16  latched operand A.
- rt_p1  out  16  latched operand B.
- rd_p1  out  16  combinational stage result.
- wr_success_p1  out  1  a write completed last cycle.
- epc_p1  out  16  exception PC.
- alu_output_valid  out  1  rd_p1 valid.

Behaviour:
- Reset (async, rst=1): all 8 registers, rs_p1, rt_p1, epc_p1 = 0; wr_success_p1 = 0.
- Writeback: at posedge with en & wr, reg[rd_in] <= data_in. R0 is a normal writable register.
- wr_success_p1 <= en & wr every edge (1-cycle pulse per write).
- Operand latch: at posedge with en, rs_p1 <= reg[rs_in] and rt_p1 <= reg[rt_in]. With en=0 they hold.
- Read-during-write: the latch captures the pre-write (old) value.
- Exception: at posedge with en & excep, epc_p1 <= pc; otherwise epc_p1 holds.
- Shifter (combinational, always active):
  - amt = rt_p1[3:0].
  - rot = uop_cnt_idix_p1[4]; right = rotate_shift_right_idix_p1.
  - rot=0, right=1: logical right shift, zero fill (no sign extension; 0x8FFF>>1 = 0x47FF).
  - rot=0, right=0: logical left shift, zero fill.
  - rot=1: rotate in the selected direction.
  - amt=0 returns rs_p1 unchanged.
- ALU by opcode_idix_p1 (A=rs_p1, B=rt_p1, all modulo 2^16):
  - 0: A+B
  - 1: B-A
  - 2: A^B
  - 3: A&~B
  - 4: shifter result
  - 5: A==B
  - 6: signed A<B
  - 7: signed A<=B
  - 8: carry-out of A+B
  - 9: bit-reverse A
  - 10: B
  - 11: (A<<8)|B[7:0]
  - 12: pc_p1+2
  - 13-31: 0
  - Compare and carry results are zero-extended to 16 bits.
- Result select priority:
  - jmp_idix_p1: rd_p1 = pc_p1+2.
  - else ldst_valid_idix_p1: rd_p1 = A+B.
  - else branch_idix_p1: rd_p1 = {15'b0, A==0}.
  - else the opcode result.
- alu_output_valid = execute_valid_idix_p1 & en (combinational).
- rd_p1 is valid only while alu_output_valid=1; otherwise its value is don't-care but deterministic.
- Simultaneous wr and excep: both take effect.
- Reset asserted mid-operation clears all state immediately.

Optional Feature:
- Macro EXEC_FORWARD_EN.
- Defined: when en & wr and rd_in equals rs_in (or rt_in), rs_p1 (or rt_p1) captures data_in on that same edge (write-through bypass).
- Undefined: the old register value is captured, as stated above.

Test Plan:
- Reset: rst=1 -> all outputs 0, wr_success_p1=0; after release, reading every register returns 0x0000.
- Write R3=0x1234 (en=1, wr=1), next cycle rs_in=3 -> rs_p1=0x1234 one edge later; wr_success_p1 pulses for exactly one cycle.
- Shift sweep: rs_p1=0x8FFF, rot=0, right=1, amt 0..15 -> rd_p1 (opcode 4) = 0x8FFF>>amt; repeat with right=0 -> 0x8FFF<<amt truncated to 16 bits.
- Rotate: A=0x8001, rot=1, amt=1 -> left gives 0x0003, right gives 0xC000.
- ALU/priority:
  - A=0xFFFF, B=0x0001, opcode 8 -> 0x0001.
  - opcode 6 -> 0x0001.
  - jmp=1 with pc_p1=0x0100 -> 0x0102 regardless of opcode.
- Exception and forwarding:
  - excep=1, pc=0x00AA, en=1 -> epc_p1=0x00AA; with en=0 it holds.
  - Same-edge write/read of R5 -> old value captured, or new value when EXEC_FORWARD_EN is defined.
